grad_mag_sq: RTL and testbench

- Upstream feeder for sqrRoot in the particle-detector gradient path.
- Takes signed Sobel gradients (gx, gy) per pixel and produces the unsigned 32-bit magnitude-squared gx²+gy². sqrRoot consumes this as invalue.
- 3-stage pipeline with valid/ready backpressure and bubble collapse.
- Frame sideband (sof/eol) travels with the data; a saturation counter supports debug.

---
 rtl/grad_mag_sq_pkg.sv | 15 +
 rtl/grad_mag_sq_pipe_stage_ctl.sv | 22 ++
 rtl/grad_mag_sq.sv | 145 ++++++++++++++
 tb/tb_grad_mag_sq.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grad_mag_sq_pkg.sv
// Shared types and defaults for the gradient magnitude-squared path feeding sqrRoot.
package grad_mag_sq_pkg;

  localparam int unsigned GW_DEF = 16;
  localparam int unsigned OW_DEF = 32;
  localparam int unsigned CW_DEF = 16;

  localparam logic [OW_DEF-1:0] SAT_LIMIT = '1;

  typedef struct packed {
    logic sof;
    logic eol;
  } sideband_t;

endpackage

// File: rtl/grad_mag_sq_pipe_stage_ctl.sv
// One pipeline stage's valid flag and advance enable; data registers live in the parent.
module pipe_stage_ctl (
  input  logic clk,
  input  logic rst,
  input  logic prev_valid,
  input  logic next_adv,
  output logic valid,
  output logic adv
);

  // A stage may load when it is empty or its content is moving on this edge.
  always_comb adv = !valid || next_adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (adv) begin
      valid <= prev_valid;
    end
  end

endmodule

// File: rtl/grad_mag_sq.sv
// gx^2 + gy^2 over a 3-stage valid/ready pipeline with bubble collapse and
// a saturation event counter for debug.
module grad_mag_sq
  import grad_mag_sq_pkg::*;
#(
  parameter int unsigned GW = GW_DEF,
  parameter int unsigned OW = OW_DEF,
  parameter int unsigned CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [GW-1:0] in_gx,
  input  logic [GW-1:0] in_gy,
  input  logic          in_sof,
  input  logic          in_eol,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_magsq,
  output logic          out_sof,
  output logic          out_eol,
  output logic [CW-1:0] sat_count,
  input  logic          sat_clr
);

  localparam int unsigned SW = 2 * GW + 1;
  localparam logic [OW-1:0] MAG_MAX = '1;
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic v1, v2, v3;
  logic adv1, adv2, adv3;

  pipe_stage_ctl u_s1 (
    .clk        (clk),
    .rst        (rst),
    .prev_valid (in_valid),
    .next_adv   (adv2),
    .valid      (v1),
    .adv        (adv1)
  );

  pipe_stage_ctl u_s2 (
    .clk        (clk),
    .rst        (rst),
    .prev_valid (v1),
    .next_adv   (adv3),
    .valid      (v2),
    .adv        (adv2)
  );

  pipe_stage_ctl u_s3 (
    .clk        (clk),
    .rst        (rst),
    .prev_valid (v2),
    .next_adv   (out_ready),
    .valid      (v3),
    .adv        (adv3)
  );

  always_comb begin
    in_ready  = adv1;
    out_valid = v3;
  end

  // Two's-complement magnitude; the most negative input maps to 2^(GW-1) unsigned.
  function automatic logic [GW-1:0] abs_u(input logic [GW-1:0] v);
    return v[GW-1] ? (~v + 1'b1) : v;
  endfunction

  logic [GW-1:0]   ax_q, ay_q;
  logic [2*GW-1:0] sqx_q, sqy_q;
  sideband_t       sb1_q, sb2_q, sb3_q;
  logic [SW-1:0]   sum;
  logic [OW-1:0]   mag_d, mag_q;
  logic            sat_d, sat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ax_q  <= '0;
      ay_q  <= '0;
      sb1_q <= '0;
    end else if (adv1) begin
      ax_q  <= abs_u(in_gx);
      ay_q  <= abs_u(in_gy);
      sb1_q <= '{sof: in_sof, eol: in_eol};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sqx_q <= '0;
      sqy_q <= '0;
      sb2_q <= '0;
    end else if (adv2) begin
      sqx_q <= {{GW{1'b0}}, ax_q} * {{GW{1'b0}}, ax_q};
      sqy_q <= {{GW{1'b0}}, ay_q} * {{GW{1'b0}}, ay_q};
      sb2_q <= sb1_q;
    end
  end

  always_comb sum = {1'b0, sqx_q} + {1'b0, sqy_q};

  // Saturation logic only exists when the full sum can exceed the output width.
  generate
    if (SW > OW) begin : g_sat
      always_comb begin
        sat_d = |sum[SW-1:OW];
        mag_d = sat_d ? MAG_MAX : sum[OW-1:0];
      end
    end else begin : g_nosat
      always_comb begin
        sat_d = 1'b0;
        mag_d = OW'(sum);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      mag_q <= '0;
      sat_q <= 1'b0;
      sb3_q <= '0;
    end else if (adv3) begin
      mag_q <= mag_d;
      sat_q <= sat_d;
      sb3_q <= sb2_q;
    end
  end

  always_comb begin
    out_magsq = mag_q;
    out_sof   = sb3_q.sof;
    out_eol   = sb3_q.eol;
  end

  always_ff @(posedge clk) begin
    if (rst || sat_clr) begin
      sat_count <= '0;
    end else if (v3 && out_ready && sat_q && (sat_count != CNT_MAX)) begin
      sat_count <= sat_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_grad_mag_sq.sv
// Scoreboard bench for grad_mag_sq: default build plus a GW=17 build for saturation.
module tb_grad_mag_sq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Default-width DUT
  logic        rst;
  logic        in_valid, in_ready, in_sof, in_eol;
  logic [15:0] in_gx, in_gy;
  logic        out_valid, out_ready, out_sof, out_eol;
  logic [31:0] out_magsq;
  logic [15:0] sat_count;
  logic        sat_clr;

  grad_mag_sq u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_gx     (in_gx),
    .in_gy     (in_gy),
    .in_sof    (in_sof),
    .in_eol    (in_eol),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_magsq (out_magsq),
    .out_sof   (out_sof),
    .out_eol   (out_eol),
    .sat_count (sat_count),
    .sat_clr   (sat_clr)
  );

  // Widened DUT where saturation is reachable
  logic        s_in_valid, s_in_ready, s_sof, s_eol;
  logic [16:0] s_gx, s_gy;
  logic        s_out_valid, s_out_ready, s_out_sof, s_out_eol;
  logic [31:0] s_magsq;
  logic [15:0] s_sat_count;
  logic        s_sat_clr;

  grad_mag_sq #(.GW(17), .OW(32), .CW(16)) u_sat (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_gx     (s_gx),
    .in_gy     (s_gy),
    .in_sof    (s_sof),
    .in_eol    (s_eol),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_magsq (s_magsq),
    .out_sof   (s_out_sof),
    .out_eol   (s_out_eol),
    .sat_count (s_sat_count),
    .sat_clr   (s_sat_clr)
  );

  typedef struct {
    logic [31:0] mag;
    logic        sof;
    logic        eol;
  } exp_t;

  exp_t sbq[$];
  int   n_in  = 0;
  int   n_out = 0;

  logic        hold_prev = 1'b0;
  logic [31:0] prev_mag;
  logic        prev_sof, prev_eol;

  // Handshakes are sampled mid-cycle; inputs only change just after posedge.
  always @(negedge clk) begin
    exp_t   e;
    longint a, b, s;
    if (rst) begin
      sbq.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        n_checks++;
        if ({out_valid, out_magsq, out_sof, out_eol} !== {1'b1, prev_mag, prev_sof, prev_eol}) begin
          n_fail++;
          $display("FAIL hold_stable: got v=%0b mag=%0d sof=%0b eol=%0b, need v=1 mag=%0d sof=%0b eol=%0b",
                   out_valid, out_magsq, out_sof, out_eol, prev_mag, prev_sof, prev_eol);
        end
      end
      hold_prev = out_valid && !out_ready;
      prev_mag  = out_magsq;
      prev_sof  = out_sof;
      prev_eol  = out_eol;

      if (out_valid && out_ready) begin
        n_checks++;
        n_out++;
        if (sbq.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got mag=%0d with no beat outstanding, need none", out_magsq);
        end else begin
          e = sbq.pop_front();
          if ({out_magsq, out_sof, out_eol} !== {e.mag, e.sof, e.eol}) begin
            n_fail++;
            $display("FAIL sb_beat: got mag=%0d sof=%0b eol=%0b, need mag=%0d sof=%0b eol=%0b",
                     out_magsq, out_sof, out_eol, e.mag, e.sof, e.eol);
          end
        end
      end

      if (in_valid && in_ready) begin
        a = longint'($signed(in_gx));
        b = longint'($signed(in_gy));
        s = a * a + b * b;
        if (s > 64'sd4294967295) s = 64'sd4294967295;
        e.mag = s[31:0];
        e.sof = in_sof;
        e.eol = in_eol;
        sbq.push_back(e);
        n_in++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_gx = '0; in_gy = '0; in_sof = 1'b0; in_eol = 1'b0;
    out_ready = 1'b0; sat_clr = 1'b0;
    s_in_valid = 1'b0; s_gx = '0; s_gy = '0; s_sof = 1'b0; s_eol = 1'b0;
    s_out_ready = 1'b0; s_sat_clr = 1'b0;
    cyc(); cyc();
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_magsq, out_sof, out_eol, sat_count} !== {1'b0, 32'd0, 1'b0, 1'b0, 16'd0}) begin
      n_fail++;
      $display("FAIL reset_state: got v=%0b mag=%0d sof=%0b eol=%0b cnt=%0d, need all 0",
               out_valid, out_magsq, out_sof, out_eol, sat_count);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %0b, need 1", in_ready);
    end
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    in_valid = 1'b1; in_gx = 16'sd3; in_gy = -16'sd4; in_sof = 1'b1; in_eol = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_accept: got in_ready=%0b, need 1", in_ready);
    end
    cyc();
    in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (i < 3) begin
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL basic_early: got out_valid=%0b at cycle %0d, need 0", out_valid, i);
        end
      end else if ({out_valid, out_magsq, out_sof, out_eol} !== {1'b1, 32'd25, 1'b1, 1'b1}) begin
        n_fail++;
        $display("FAIL basic_latency: got v=%0b mag=%0d sof=%0b eol=%0b, need v=1 mag=25 sof=1 eol=1",
                 out_valid, out_magsq, out_sof, out_eol);
      end
      cyc();
    end
  endtask

  task automatic test_extremes();
    logic [15:0] gx_t[3];
    logic [15:0] gy_t[3];
    logic [31:0] ex_t[3];
    gx_t = '{16'h8000, 16'h7FFF, 16'h0000};
    gy_t = '{16'h8000, 16'h0000, 16'h0000};
    ex_t = '{32'd2147483648, 32'd1073676289, 32'd0};
    out_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      in_valid = 1'b1; in_gx = gx_t[b]; in_gy = gy_t[b];
      in_sof = (b == 0); in_eol = (b == 2);
      cyc();
    end
    in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      n_checks++;
      if ({out_valid, out_magsq} !== {1'b1, ex_t[b]}) begin
        n_fail++;
        $display("FAIL extreme_%0d: got v=%0b mag=%0d, need v=1 mag=%0d", b, out_valid, out_magsq, ex_t[b]);
      end
      cyc();
    end
  endtask

  task automatic test_backpressure();
    int k = 1;
    int acc = 0;
    int ej;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_gx = 16'(k); in_gy = '0; in_sof = (k == 1); in_eol = (k == 5);
      @(negedge clk);
      if (c == 3) begin
        n_checks++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_fourth_held: got in_ready=%0b, need 0", in_ready);
        end
      end
      if (c >= 3) begin
        n_checks++;
        if ({out_valid, out_magsq} !== {1'b1, 32'd1}) begin
          n_fail++;
          $display("FAIL bp_hold_first: got v=%0b mag=%0d, need v=1 mag=1", out_valid, out_magsq);
        end
      end
      if (in_ready) begin
        acc++;
        k++;
      end
      cyc();
    end
    n_checks++;
    if (acc != 3) begin
      n_fail++;
      $display("FAIL bp_accept_count: got %0d, need 3", acc);
    end
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      if (k <= 5) begin
        in_valid = 1'b1; in_gx = 16'(k); in_gy = '0; in_sof = 1'b0; in_eol = (k == 5);
      end else begin
        in_valid = 1'b0; in_eol = 1'b0;
      end
      @(negedge clk);
      ej = (j + 1) * (j + 1);
      n_checks++;
      if ({out_valid, out_magsq} !== {1'b1, 32'(ej)}) begin
        n_fail++;
        $display("FAIL bp_drain_%0d: got v=%0b mag=%0d, need v=1 mag=%0d", j, out_valid, out_magsq, ej);
      end
      if (j == 0) begin
        n_checks++;
        if (in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL bp_simultaneous: got in_ready=%0b, need 1", in_ready);
        end
      end
      if (in_valid && in_ready) k++;
      cyc();
    end
    in_valid = 1'b0; in_eol = 1'b0;
  endtask

  task automatic test_random();
    int sent = 0;
    int c = 0;
    int in0 = n_in;
    int out0 = n_out;
    while (sent < 10000 && c < 60000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_gx     = 16'($urandom);
      in_gy     = 16'($urandom);
      if ($urandom_range(0, 15) == 0) in_gx = 16'h8000;
      in_sof    = ($urandom_range(0, 31) == 0);
      in_eol    = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      cyc();
      c++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    c = 0;
    while (sbq.size() != 0 && c < 50) begin
      cyc();
      c++;
    end
    n_checks++;
    if (sent != 10000 || sbq.size() != 0) begin
      n_fail++;
      $display("FAIL rand_complete: got sent=%0d pending=%0d, need sent=10000 pending=0", sent, sbq.size());
    end
    n_checks++;
    if ((n_out - out0) != (n_in - in0)) begin
      n_fail++;
      $display("FAIL rand_count: got %0d outputs, need %0d", n_out - out0, n_in - in0);
    end
    n_checks++;
    if (sat_count !== 16'd0) begin
      n_fail++;
      $display("FAIL rand_no_sat: got sat_count=%0d, need 0", sat_count);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      in_valid = 1'b1; in_gx = 16'(b + 7); in_gy = '0;
      cyc();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_flush: got out_valid=%0b, need 0", out_valid);
    end
    cyc();
    in_valid = 1'b1; in_gx = 16'sd5; in_gy = 16'sd12; in_sof = 1'b1; in_eol = 1'b0;
    cyc();
    in_valid = 1'b0; in_sof = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (i < 3) begin
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL rstmid_stale: got out_valid=%0b mag=%0d at cycle %0d, need 0", out_valid, out_magsq, i);
        end
      end else if ({out_valid, out_magsq, out_sof} !== {1'b1, 32'd169, 1'b1}) begin
        n_fail++;
        $display("FAIL rstmid_first: got v=%0b mag=%0d sof=%0b, need v=1 mag=169 sof=1",
                 out_valid, out_magsq, out_sof);
      end
      cyc();
    end
  endtask

  task automatic test_saturation();
    s_out_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      s_in_valid = 1'b1;
      s_gx = (r == 2) ? 17'd3 : 17'h10000;
      s_gy = (r == 2) ? 17'd4 : 17'h10000;
      cyc();
      s_in_valid = 1'b0;
      cyc();
      cyc();
      s_sat_clr = (r == 1);
      @(negedge clk);
      n_checks++;
      if ({s_out_valid, s_magsq} !== {1'b1, (r == 2) ? 32'd25 : 32'hFFFFFFFF}) begin
        n_fail++;
        $display("FAIL sat_mag_%0d: got v=%0b mag=%0d, need v=1 mag=%0d", r, s_out_valid, s_magsq,
                 (r == 2) ? 32'd25 : 32'hFFFFFFFF);
      end
      cyc();
      s_sat_clr = 1'b0;
      n_checks++;
      if (s_sat_count !== ((r == 0) ? 16'd1 : 16'd0)) begin
        n_fail++;
        $display("FAIL sat_count_%0d: got %0d, need %0d", r, s_sat_count, (r == 0) ? 1 : 0);
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, need completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_saturation();
    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL final_pending: got %0d beats outstanding, need 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
